// File: rtl/xgriscv_dmem_if.sv
// xgriscv data-memory port: request/response handshake between CPU and dmem.
// busy lets the CPU stall its memory stage while a request is in flight.
interface xgriscv_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_size,
        output req_unsigned,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_size,
        input  req_unsigned,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output busy
    );
endinterface

// File: rtl/xgriscv_dmem.sv
// Multi-cycle data memory with wait states and RISC-V sub-word access.
// One request in flight; response is a single-cycle pulse with registered data.
module xgriscv_dmem #(
    parameter int    DEPTH_LOG2 = 10,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic          clk,
    input  logic          rst,
    xgriscv_dmem_if.slave bus
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 =
        (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem_q [WORDS];

    logic        hs;
    logic        enter_resp;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic        cur_uns;
    logic [31:0] cur_wdata;

    logic                  err;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rword;
    logic [7:0]            rbyte;
    logic [15:0]           rhalf;
    logic [31:0]           ldata;
    logic [3:0]            be;
    logic [31:0]           wrep;
    logic                  mem_we;

    assign hs = bus.req_valid && (state_q == S_IDLE);

    // With zero wait states the commit edge is the handshake edge itself,
    // so the live request must be used before it lands in the capture regs.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_size  = size_q;
        cur_uns   = uns_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_size  = bus.req_size;
            cur_uns   = bus.req_unsigned;
            cur_wdata = bus.req_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_comb begin
        err = 1'b0;
        unique case (cur_size)
            2'b00: err = 1'b0;
            2'b01: err = cur_addr[0];
            2'b10: err = (cur_addr[1:0] != 2'b00);
            default: err = 1'b1;
        endcase
        if (|(cur_addr[31:2] >> DEPTH_LOG2)) begin
            err = 1'b1;
        end
    end

    assign idx   = cur_addr[DEPTH_LOG2+1:2];
    assign rword = mem_q[idx];
    assign rbyte = rword[{cur_addr[1:0], 3'b000} +: 8];
    assign rhalf = rword[{cur_addr[1], 4'b0000} +: 16];

    always_comb begin
        ldata = rword;
        wrep  = cur_wdata;
        be    = 4'b0000;
        unique case (cur_size)
            2'b00: begin
                ldata = cur_uns ? {24'b0, rbyte}
                                : {{24{rbyte[7]}}, rbyte};
                wrep  = {4{cur_wdata[7:0]}};
                be    = 4'b0001 << cur_addr[1:0];
            end
            2'b01: begin
                ldata = cur_uns ? {16'b0, rhalf}
                                : {{16{rhalf[15]}}, rhalf};
                wrep  = {2{cur_wdata[15:0]}};
                be    = 4'b0011 << cur_addr[1:0];
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Gate on rst so a request seen while reset is held never commits.
    assign mem_we = enter_resp && cur_we && !err && rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wrep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hs) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                wdata_q <= bus.req_wdata;
            end
            if (enter_resp) begin
                err_q   <= err;
                rdata_q <= (err || cur_we) ? 32'd0 : ldata;
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_xgriscv_dmem.sv
// Self-checking bench for xgriscv_dmem: LATENCY=2 and LATENCY=0 instances.
// Expected responses are queued at accept and popped when resp_valid is seen.
module tb_xgriscv_dmem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xgriscv_dmem_if bus ();
  xgriscv_dmem_if bus0 ();

  xgriscv_dmem #(
    .DEPTH_LOG2(10),
    .LATENCY(2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  xgriscv_dmem #(
    .DEPTH_LOG2(10),
    .LATENCY(0)
  ) u_dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } req_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request on the LATENCY=2 port; returns accept edge or -1.
  task automatic issue(input req_t r, input bit push, output int acc);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = r.we;
    bus.req_addr     = r.addr;
    bus.req_size     = r.size;
    bus.req_unsigned = r.uns;
    bus.req_wdata    = r.wdata;
    for (int i = 0; i < 40 && !bus.req_ready; i++) @(negedge clk);
    acc = -1;
    if (bus.req_ready) begin
      @(posedge clk);
      #1;
      acc = cyc;
      if (push) sbq.push_back('{rdata: r.exp_rd, err: r.exp_err});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Waits for resp_valid; 'at' is the cycle index in which it is visible.
  task automatic wait_resp(output logic [31:0] rd, output logic er,
                           output int at, output bit to);
    to = 1'b1;
    rd = 'x;
    er = 1'bx;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.resp_valid) begin
        rd = bus.resp_rdata;
        er = bus.resp_err;
        at = cyc + 1;
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_table(input string tag, input req_t t[]);
    int acc, at;
    bit to;
    logic [31:0] rd;
    logic er;
    exp_t e;
    foreach (t[i]) begin
      issue(t[i], 1'b1, acc);
      wait_resp(rd, er, at, to);
      checks++;
      if (acc < 0 || to || sbq.size() == 0) begin
        failures++;
        $display("FAIL %s[%0d] timeout acc=%0d to=%0b", tag, i, acc, to);
        continue;
      end
      e = sbq.pop_front();
      if (rd !== e.rdata) begin
        failures++;
        $display("FAIL %s[%0d] rdata got=%h exp=%h", tag, i, rd, e.rdata);
      end
      checks++;
      if (er !== e.err) begin
        failures++;
        $display("FAIL %s[%0d] err got=%b exp=%b", tag, i, er, e.err);
      end
      checks++;
      if (at - acc !== 3) begin
        failures++;
        $display("FAIL %s[%0d] latency got=%0d exp=3", tag, i, at - acc);
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s[%0d] pulse got=%b exp=0", tag, i, bus.resp_valid);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0;
    bus.req_size = 0; bus.req_unsigned = 0; bus.req_wdata = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0;
    bus0.req_size = 0; bus0.req_unsigned = 0; bus0.req_wdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.busy, bus.resp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=100",
               {bus.req_ready, bus.busy, bus.resp_valid});
    end
    checks++;
    if ({bus.resp_rdata, bus.resp_err} !== 33'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%b exp=0/0",
               bus.resp_rdata, bus.resp_err);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err} !== 4'b1000
          || bus.resp_rdata !== 32'd0) begin
        failures++;
        $display("FAIL idle[%0d] got=%b/%h exp=1000/0", i,
                 {bus.req_ready, bus.busy, bus.resp_valid, bus.resp_err},
                 bus.resp_rdata);
      end
    end
  endtask

  task automatic test_word;
    req_t t[];
    int acc;
    t = new[2];
    t[0] = '{1'b1, 32'h40, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0};
    t[1] = '{1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0};
    run_table("word", t);
    issue('{1'b0, 32'h40, 2'b10, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0}, 1'b1, acc);
    checks++;
    if ({bus.busy, bus.req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL busy_wait got=%b exp=10", {bus.busy, bus.req_ready});
    end
    for (int i = 0; i < 5 && !bus.resp_valid; i++) @(negedge clk);
    checks++;
    if (sbq.size() == 0 || bus.resp_rdata !== sbq[0].rdata) begin
      failures++;
      $display("FAIL lw_uns got=%h exp=DEADBEEF", bus.resp_rdata);
    end
    if (sbq.size() != 0) void'(sbq.pop_front());
    @(negedge clk);
  endtask

  task automatic test_subword;
    req_t t[];
    t = new[6];
    t[0] = '{1'b1, 32'h41, 2'b00, 1'b0, 32'hAAAAAA80, 32'h0, 1'b0};
    t[1] = '{1'b1, 32'h42, 2'b01, 1'b0, 32'h55551234, 32'h0, 1'b0};
    t[2] = '{1'b0, 32'h41, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0};
    t[3] = '{1'b0, 32'h41, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0};
    t[4] = '{1'b0, 32'h42, 2'b01, 1'b0, 32'h0, 32'h00001234, 1'b0};
    t[5] = '{1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h123480EF, 1'b0};
    run_table("subword", t);
  endtask

  task automatic test_errors;
    req_t t[];
    t = new[6];
    t[0] = '{1'b0, 32'h42, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1};
    t[1] = '{1'b1, 32'h43, 2'b01, 1'b0, 32'hFFFF, 32'h0, 1'b1};
    t[2] = '{1'b0, 32'h40, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1};
    t[3] = '{1'b0, 32'h1000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1};
    t[4] = '{1'b1, 32'h1040, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1};
    t[5] = '{1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 32'h123480EF, 1'b0};
    run_table("err", t);
  endtask

  task automatic test_back_to_back_lat0;
    req_t t[6];
    int acc, prev;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      t[i] = '{1'b1, 32'h100 + 32'(4*i), 2'b10, 1'b0,
               32'hA0000000 + 32'(i), 32'h0, 1'b0};
      t[i+3] = '{1'b0, 32'h100 + 32'(4*i), 2'b10, 1'b0, 32'h0,
                 32'hA0000000 + 32'(i), 1'b0};
    end
    prev = -1;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus0.req_we       = t[i].we;
      bus0.req_addr     = t[i].addr;
      bus0.req_size     = t[i].size;
      bus0.req_unsigned = t[i].uns;
      bus0.req_wdata    = t[i].wdata;
      for (int k = 0; k < 10 && !bus0.req_ready; k++) @(negedge clk);
      @(posedge clk);
      #1;
      acc = cyc;
      sbq.push_back('{rdata: t[i].exp_rd, err: t[i].exp_err});
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (bus0.resp_valid !== 1'b1 || bus0.resp_rdata !== e.rdata
          || bus0.resp_err !== e.err) begin
        failures++;
        $display("FAIL lat0[%0d] got=%b/%h/%b exp=1/%h/%b", i,
                 bus0.resp_valid, bus0.resp_rdata, bus0.resp_err,
                 e.rdata, e.err);
      end
      if (i > 0) begin
        checks++;
        if (acc - prev !== 2) begin
          failures++;
          $display("FAIL lat0_gap[%0d] got=%0d exp=2", i, acc - prev);
        end
      end
      prev = acc;
    end
    bus0.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    req_t t[];
    int acc;
    bit seen;
    t = new[1];
    t[0] = '{1'b1, 32'h80, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0};
    run_table("pre", t);
    issue('{1'b1, 32'h80, 2'b10, 1'b0, 32'h55AA55AA, 32'h0, 1'b0}, 1'b0, acc);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.busy, bus.resp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=100",
               {bus.req_ready, bus.busy, bus.resp_valid});
    end
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_noresp got=%b exp=0", seen);
    end
    t[0] = '{1'b0, 32'h80, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0};
    run_table("post", t);
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_back_to_back_lat0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
